// File: rtl/mat_mult_stream_pkg.sv
// ============================================================================
// Module   : mat_mult_pkg
// Purpose  : Shared types and helpers for the streaming matrix multiplier:
//            the control state encoding, width helpers and the output
//            conversion (saturate / wrap plus overflow detection).
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mat_mult_pkg;

   // Control states of the job sequencer.
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD_A  = 3'd1,
      LOAD_B  = 3'd2,
      COMPUTE = 3'd3,
      OUTPUT  = 3'd4,
      DONE    = 3'd5
   } state_t;

   // Working width of the conversion helper. Accumulators are sign-extended
   // into this width before conversion, so AW must stay below SAT_W.
   localparam int SAT_W = 64;

   // Result of an output conversion: the converted value (caller keeps the
   // low DW bits) and whether the unconverted value fell outside the range.
   typedef struct packed {
      logic [SAT_W-1:0] word;
      logic             ovf;
   } sat_t;

   // Counter/index width for a count of n items; never narrower than 1 bit.
   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Converts a signed full-width value to a dw-bit result.
   // sgn selects the two's-complement or unsigned dw-bit range; sat_en clamps
   // to that range, otherwise the low bits pass through unchanged. The
   // overflow bit only depends on the range, never on sat_en.
   function automatic sat_t saturate(input logic signed [SAT_W-1:0] value,
                                     input int                      dw,
                                     input logic                    sgn,
                                     input logic                    sat_en);
      logic signed [SAT_W-1:0] one;
      logic signed [SAT_W-1:0] lo;
      logic signed [SAT_W-1:0] hi;
      sat_t                    res;
      one = SAT_W'(1);
      if (sgn) begin
         hi = (one <<< (dw - 1)) - one;
         lo = -(one <<< (dw - 1));
      end else begin
         hi = (one <<< dw) - one;
         lo = '0;
      end
      res.ovf  = (value < lo) || (value > hi);
      res.word = value;
      if (sat_en && (value > hi)) begin
         res.word = hi;
      end else if (sat_en && (value < lo)) begin
         res.word = lo;
      end
      return res;
   endfunction

endpackage : mat_mult_pkg

`default_nettype wire

// File: rtl/mat_mult_stream_if.sv
// ============================================================================
// Module   : mat_mult_stream_if
// Purpose  : Valid/ready word stream used for operand input and result
//            output of the matrix multiplier.
// Ports    : master - drives valid/data, receives ready
//            slave  - receives valid/data, drives ready
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mat_mult_stream_if #(
   parameter int DW = 8
) ();

   logic          valid;
   logic          ready;
   logic [DW-1:0] data;

   modport master (
      output valid,
      output data,
      input  ready
   );

   modport slave (
      input  valid,
      input  data,
      output ready
   );

endinterface : mat_mult_stream_if

`default_nettype wire

// File: rtl/mat_mult_stream_mac.sv
// ============================================================================
// Module   : mac_unit
// Purpose  : Single multiply-accumulate lane. Operands are sign- or
//            zero-extended to the accumulator width, multiplied and added
//            to the running sum. Clear has priority over enable.
// Ports    : clk, rst (async, active-low)
//            clr_i  - zero the accumulator
//            en_i   - add a_i*b_i to the accumulator
//            sgn_i  - 1: operands are two's complement, 0: unsigned
//            a_i, b_i (DW) - operands
//            acc_o  (AW)   - accumulator value
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_unit
   import mat_mult_pkg::*;
#(
   parameter int DW = 8,
   parameter int AW = 2*DW + 2
) (
   input  wire logic          clk,
   input  wire logic          rst,
   input  wire logic          clr_i,
   input  wire logic          en_i,
   input  wire logic          sgn_i,
   input  wire logic [DW-1:0] a_i,
   input  wire logic [DW-1:0] b_i,
   output logic      [AW-1:0] acc_o
);

   logic [AW-1:0] acc_q;
   logic [AW-1:0] acc_d;
   logic [AW-1:0] w_a_ext;
   logic [AW-1:0] w_b_ext;
   logic [AW-1:0] w_prod;

   // Modulo-2^AW arithmetic gives the correct low AW bits of the signed
   // product once both operands are extended to AW.
   assign w_a_ext = {{(AW-DW){sgn_i & a_i[DW-1]}}, a_i};
   assign w_b_ext = {{(AW-DW){sgn_i & b_i[DW-1]}}, b_i};
   assign w_prod  = w_a_ext * w_b_ext;

   always_comb begin
      acc_d = acc_q;
      if (clr_i) begin
         acc_d = '0;
      end else if (en_i) begin
         acc_d = acc_q + w_prod;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc_o = acc_q;

endmodule : mac_unit

`default_nettype wire

// File: rtl/mat_mult_stream.sv
// ============================================================================
// Module   : mat_mult_stream
// Purpose  : Streaming C = A x B for an MxN matrix A and an NxP matrix B.
//            Operands arrive on in_if (A row-major, then B row-major), the
//            MxP result leaves on out_if row-major. Signed/unsigned operands
//            and output saturation are selected per job.
// Ports    : clk, rst (async, active-low)
//            start, sgn, sat_en       - job control, sampled in IDLE
//            in_if  (slave stream)    - operand words
//            out_if (master stream)   - result words
//            overflow                 - sticky, a result did not fit in DW
//            busy                     - any state other than IDLE
//            done                     - one-cycle end-of-job pulse
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mat_mult_stream
   import mat_mult_pkg::*;
#(
   parameter int DW = 8,
   parameter int M  = 2,
   parameter int N  = 2,
   parameter int P  = 2,
   parameter int AW = 2*DW + $clog2(N) + 1
) (
   input  wire logic         clk,
   input  wire logic         rst,
   input  wire logic         start,
   input  wire logic         sgn,
   input  wire logic         sat_en,
   mat_mult_stream_if.slave  in_if,
   mat_mult_stream_if.master out_if,
   output logic             overflow,
   output logic             busy,
   output logic             done
);

   localparam int AI_W = cnt_w(M*N);
   localparam int BI_W = cnt_w(N*P);
   localparam int CI_W = cnt_w(M*P);
   localparam int LD_W = cnt_w((M*N > N*P) ? M*N : N*P);
   localparam int I_W  = cnt_w(M);
   localparam int J_W  = cnt_w(P);
   localparam int K_W  = cnt_w(N+1);

   // ------------------------------------------------------------------
   // State, counters and job settings
   // ------------------------------------------------------------------
   state_t            state_q;
   state_t            state_d;
   logic [LD_W-1:0]   ld_cnt_q;
   logic [I_W-1:0]    i_q;
   logic [J_W-1:0]    j_q;
   logic [K_W-1:0]    k_q;
   logic [CI_W-1:0]   o_cnt_q;
   logic              ovf_q;
   logic              sgn_q;
   logic              sat_en_q;

   // Matrix storage; content is don't-care outside a job, so no reset.
   logic [DW-1:0]     a_mem_q [M*N];
   logic [DW-1:0]     b_mem_q [N*P];
   logic [AW-1:0]     c_mem_q [M*P];

   // ------------------------------------------------------------------
   // Combinational control
   // ------------------------------------------------------------------
   logic              w_in_ready;
   logic              w_out_valid;
   logic              w_busy;
   logic              w_done;
   logic              w_mac_clr;
   logic              w_mac_en;
   logic              w_c_wr;
   logic              w_ld_last_a;
   logic              w_ld_last_b;
   logic              w_wr_cycle;
   logic              w_last_i;
   logic              w_last_j;
   logic              w_out_last;
   logic [K_W-1:0]    w_k_rd;
   logic [AI_W-1:0]   w_a_rd_idx;
   logic [BI_W-1:0]   w_b_rd_idx;
   logic [CI_W-1:0]   w_c_wr_idx;
   logic [AW-1:0]     w_acc;
   sat_t              w_acc_sat;
   sat_t              w_out_sat;
   logic              w_unused;

   assign w_ld_last_a = (ld_cnt_q == LD_W'(M*N - 1));
   assign w_ld_last_b = (ld_cnt_q == LD_W'(N*P - 1));
   // k == N is the extra write cycle that follows the N MAC cycles.
   assign w_wr_cycle  = (k_q == K_W'(N));
   assign w_last_i    = (i_q == I_W'(M - 1));
   assign w_last_j    = (j_q == J_W'(P - 1));
   assign w_out_last  = (o_cnt_q == CI_W'(M*P - 1));

   // Next-state and control outputs. Handshake terms use in_if.valid and
   // out_if.ready directly so ready/valid stay functions of state only.
   always_comb begin
      state_d     = state_q;
      w_in_ready  = 1'b0;
      w_out_valid = 1'b0;
      w_busy      = 1'b1;
      w_done      = 1'b0;
      w_mac_clr   = 1'b0;
      w_mac_en    = 1'b0;
      w_c_wr      = 1'b0;
      case (state_q)
         IDLE: begin
            w_busy = 1'b0;
            if (start) begin
               state_d   = LOAD_A;
               w_mac_clr = 1'b1;
            end
         end
         LOAD_A: begin
            w_in_ready = 1'b1;
            if (in_if.valid && w_ld_last_a) begin
               state_d = LOAD_B;
            end
         end
         LOAD_B: begin
            w_in_ready = 1'b1;
            if (in_if.valid && w_ld_last_b) begin
               state_d = COMPUTE;
            end
         end
         COMPUTE: begin
            if (w_wr_cycle) begin
               w_mac_clr = 1'b1;
               w_c_wr    = 1'b1;
               if (w_last_i && w_last_j) begin
                  state_d = OUTPUT;
               end
            end else begin
               w_mac_en = 1'b1;
            end
         end
         OUTPUT: begin
            w_out_valid = 1'b1;
            if (out_if.ready && w_out_last) begin
               state_d = DONE;
            end
         end
         DONE: begin
            w_done  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Operand and result addressing. During the write cycle k is parked at 0
   // so the read index never runs past the end of A or B.
   always_comb begin
      w_k_rd     = w_wr_cycle ? '0 : k_q;
      w_a_rd_idx = AI_W'(int'(i_q) * N + int'(w_k_rd));
      w_b_rd_idx = BI_W'(int'(w_k_rd) * P + int'(j_q));
      w_c_wr_idx = CI_W'(int'(i_q) * P + int'(j_q));
   end

   // ------------------------------------------------------------------
   // Counters, job settings and sticky overflow
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ld_cnt_q <= '0;
         i_q      <= '0;
         j_q      <= '0;
         k_q      <= '0;
         o_cnt_q  <= '0;
         ovf_q    <= 1'b0;
         sgn_q    <= 1'b0;
         sat_en_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  ld_cnt_q <= '0;
                  i_q      <= '0;
                  j_q      <= '0;
                  k_q      <= '0;
                  o_cnt_q  <= '0;
                  ovf_q    <= 1'b0;
                  sgn_q    <= sgn;
                  sat_en_q <= sat_en;
               end
            end
            LOAD_A: begin
               if (in_if.valid) begin
                  ld_cnt_q <= w_ld_last_a ? '0 : ld_cnt_q + LD_W'(1);
               end
            end
            LOAD_B: begin
               if (in_if.valid) begin
                  ld_cnt_q <= w_ld_last_b ? '0 : ld_cnt_q + LD_W'(1);
               end
            end
            COMPUTE: begin
               if (w_wr_cycle) begin
                  k_q   <= '0;
                  ovf_q <= ovf_q | w_acc_sat.ovf;
                  if (w_last_j) begin
                     j_q <= '0;
                     i_q <= w_last_i ? '0 : i_q + I_W'(1);
                  end else begin
                     j_q <= j_q + J_W'(1);
                  end
               end else begin
                  k_q <= k_q + K_W'(1);
               end
            end
            OUTPUT: begin
               if (out_if.ready) begin
                  o_cnt_q <= w_out_last ? '0 : o_cnt_q + CI_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Matrix storage
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if ((state_q == LOAD_A) && in_if.valid) begin
         a_mem_q[AI_W'(ld_cnt_q)] <= in_if.data;
      end
      if ((state_q == LOAD_B) && in_if.valid) begin
         b_mem_q[BI_W'(ld_cnt_q)] <= in_if.data;
      end
      if (w_c_wr) begin
         c_mem_q[w_c_wr_idx] <= w_acc;
      end
   end

   // ------------------------------------------------------------------
   // MAC lane
   // ------------------------------------------------------------------
   mac_unit #(
      .DW (DW),
      .AW (AW)
   ) u_mac (
      .clk   (clk),
      .rst   (rst),
      .clr_i (w_mac_clr),
      .en_i  (w_mac_en),
      .sgn_i (sgn_q),
      .a_i   (a_mem_q[w_a_rd_idx]),
      .b_i   (b_mem_q[w_b_rd_idx]),
      .acc_o (w_acc)
   );

   // ------------------------------------------------------------------
   // Output conversion. The accumulator is checked when C is written so the
   // sticky flag is settled before the first result word; C keeps the full
   // AW value and is converted again at read-out. In unsigned mode the
   // accumulator top bit is always 0, so sign extension is harmless.
   // ------------------------------------------------------------------
   assign w_acc_sat = saturate({{(SAT_W-AW){w_acc[AW-1]}}, w_acc},
                               DW, sgn_q, sat_en_q);
   assign w_out_sat = saturate({{(SAT_W-AW){c_mem_q[o_cnt_q][AW-1]}}, c_mem_q[o_cnt_q]},
                               DW, sgn_q, sat_en_q);

   assign w_unused = ^{w_acc_sat.word, w_out_sat.word[SAT_W-1:DW], w_out_sat.ovf};

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign in_if.ready  = w_in_ready;
   assign out_if.valid = w_out_valid;
   assign out_if.data  = (state_q == OUTPUT) ? w_out_sat.word[DW-1:0] : '0;
   assign overflow     = ovf_q;
   assign busy         = w_busy;
   assign done         = w_done;

endmodule : mat_mult_stream

`default_nettype wire

// File: tb/tb_mat_mult_stream.sv
// ============================================================================
// Module   : tb_mat_mult_stream
// Purpose  : Self-checking bench for mat_mult_stream. A 2x2x2 instance and a
//            2x3x1 instance share the stimulus lines; sel picks the active
//            one. Expected words come from an integer reference model and are
//            queued when a job is launched, then popped per output handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mat_mult_stream;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       start;
   logic       sgn;
   logic       sat_en;
   logic       in_valid;
   logic       out_ready;
   logic [7:0] in_data;
   int         sel;

   mat_mult_stream_if #(.DW(8)) in1 ();
   mat_mult_stream_if #(.DW(8)) out1 ();
   mat_mult_stream_if #(.DW(8)) in2 ();
   mat_mult_stream_if #(.DW(8)) out2 ();

   logic start1, start2;
   logic ovf1, busy1, done1, ovf2, busy2, done2;

   assign start1     = start && (sel == 0);
   assign start2     = start && (sel == 1);
   assign in1.valid  = in_valid && (sel == 0);
   assign in2.valid  = in_valid && (sel == 1);
   assign in1.data   = in_data;
   assign in2.data   = in_data;
   assign out1.ready = out_ready && (sel == 0);
   assign out2.ready = out_ready && (sel == 1);

   mat_mult_stream #(.DW(8), .M(2), .N(2), .P(2)) u_dut (
      .clk      (clk),
      .rst      (rst_n),
      .start    (start1),
      .sgn      (sgn),
      .sat_en   (sat_en),
      .in_if    (in1),
      .out_if   (out1),
      .overflow (ovf1),
      .busy     (busy1),
      .done     (done1)
   );

   mat_mult_stream #(.DW(8), .M(2), .N(3), .P(1)) u_dut2 (
      .clk      (clk),
      .rst      (rst_n),
      .start    (start2),
      .sgn      (sgn),
      .sat_en   (sat_en),
      .in_if    (in2),
      .out_if   (out2),
      .overflow (ovf2),
      .busy     (busy2),
      .done     (done2)
   );

   logic       o_in_ready, o_out_valid, o_ovf, o_busy, o_done;
   logic [7:0] o_data;
   assign o_in_ready  = (sel == 0) ? in1.ready  : in2.ready;
   assign o_out_valid = (sel == 0) ? out1.valid : out2.valid;
   assign o_data      = (sel == 0) ? out1.data  : out2.data;
   assign o_ovf       = (sel == 0) ? ovf1       : ovf2;
   assign o_busy      = (sel == 0) ? busy1      : busy2;
   assign o_done      = (sel == 0) ? done1      : done2;

   int n_cmp  = 0;
   int n_fail = 0;
   int a_m [6];
   int b_m [6];
   int exp_q [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   function automatic longint sx(input int w, input logic sg);
      return (sg && (w >= 128)) ? longint'(w) - 256 : longint'(w);
   endfunction

   // Launch one job on instance s, stream operands, check compute length,
   // drain results against the scoreboard and check the done/busy tail.
   task automatic run_job(input int s, input int m, input int n, input int p,
                          input logic sg, input logic st,
                          input bit bub, input bit stall, input bit poke);
      int         words [$];
      int         idx, guard, cnt, n_out, stall_cnt, ev;
      longint     v, lo, hi;
      logic [7:0] e, held;
      bit         ov, acc;

      sel    = s;
      sgn    = sg;
      sat_en = st;
      exp_q.delete();
      ov = 1'b0;
      held = '0;
      lo = sg ? -128 : 0;
      hi = sg ? 127 : 255;
      for (int i = 0; i < m; i++) begin
         for (int j = 0; j < p; j++) begin
            v = 0;
            for (int k = 0; k < n; k++) begin
               v += sx(a_m[i*n+k], sg) * sx(b_m[k*p+j], sg);
            end
            if ((v < lo) || (v > hi)) ov = 1'b1;
            if (st && (v > hi)) v = hi;
            else if (st && (v < lo)) v = lo;
            e = v[7:0];
            exp_q.push_back(int'(e));
         end
      end
      for (int x = 0; x < m*n; x++) words.push_back(a_m[x]);
      for (int x = 0; x < n*p; x++) words.push_back(b_m[x]);

      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("in_ready_after_start", o_in_ready, 1);
      check("busy_after_start", o_busy, 1);

      idx   = 0;
      guard = 0;
      while ((idx < words.size()) && (guard < 1000)) begin
         in_valid = bub ? ($urandom_range(0, 2) != 0) : 1'b1;
         in_data  = 8'(words[idx]);
         acc      = in_valid && o_in_ready;
         @(negedge clk);
         if (acc) idx++;
         guard++;
      end
      in_valid = 1'b0;
      check("load_complete", idx, words.size());
      check("in_ready_in_compute", o_in_ready, 0);

      cnt = 0;
      while (!o_out_valid && (cnt < 200)) begin
         start = (poke && (cnt == 3));
         @(negedge clk);
         cnt++;
      end
      start = 1'b0;
      check("compute_cycles", cnt, m*p*(n+1));
      check("overflow_before_output", o_ovf, ov);

      n_out     = 0;
      stall_cnt = 0;
      guard     = 0;
      while ((n_out < m*p) && (guard < 200)) begin
         if (stall && (n_out == 1) && (stall_cnt < 5)) begin
            out_ready = 1'b0;
            if (stall_cnt == 0) held = o_data;
            else check("data_stable_stall", o_data, held);
            check("valid_held_stall", o_out_valid, 1);
            stall_cnt++;
         end else begin
            out_ready = 1'b1;
         end
         acc = o_out_valid && out_ready;
         if (acc) begin
            ev = exp_q.pop_front();
            check("out_data", o_data, ev);
            n_out++;
         end
         @(negedge clk);
         guard++;
      end
      out_ready = 1'b0;
      check("outputs_seen", n_out, m*p);
      check("done_pulse", o_done, 1);
      check("busy_in_done", o_busy, 1);
      @(negedge clk);
      check("done_fall", o_done, 0);
      check("busy_fall", o_busy, 0);
      check("overflow_sticky", o_ovf, ov);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: bench did not reach its summary");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n     = 1'b1;
      start     = 1'b0;
      sgn       = 1'b0;
      sat_en    = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_data   = '0;
      sel       = 0;
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_in_ready", o_in_ready, 0);
      check("rst_out_valid", o_out_valid, 0);
      check("rst_out_data", o_data, 0);
      check("rst_overflow", o_ovf, 0);
      check("rst_busy", o_busy, 0);
      check("rst_done", o_done, 0);
      rst_n = 1'b1;

      // Identity times [1,2;3,4], unsigned, saturating.
      a_m = '{1, 0, 0, 1, 0, 0};
      b_m = '{1, 2, 3, 4, 0, 0};
      run_job(0, 2, 2, 2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

      // All 200: saturating then wrapping, overflow either way.
      a_m = '{200, 200, 200, 200, 0, 0};
      b_m = '{200, 200, 200, 200, 0, 0};
      run_job(0, 2, 2, 2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      run_job(0, 2, 2, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Signed [-1,2;3,-4] x [5,6;7,8].
      a_m = '{255, 2, 3, 252, 0, 0};
      b_m = '{5, 6, 7, 8, 0, 0};
      run_job(0, 2, 2, 2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

      // Non-square 2x3 x 3x1 with input bubbles and a mid-output stall.
      a_m = '{1, 2, 3, 4, 5, 6};
      b_m = '{1, 1, 1, 0, 0, 0};
      run_job(1, 2, 3, 1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);

      // Reset pulse while in LOAD_B discards the partial job.
      sel    = 0;
      sgn    = 1'b0;
      sat_en = 1'b1;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int x = 0; x < 6; x++) begin
         in_valid = 1'b1;
         in_data  = 8'(x + 1);
         @(negedge clk);
      end
      check("busy_in_load_b", o_busy, 1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_busy", o_busy, 0);
      check("rst_mid_in_ready", o_in_ready, 0);
      check("rst_mid_overflow", o_ovf, 0);
      check("rst_mid_out_valid", o_out_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check("idle_after_rst_busy", o_busy, 0);
      check("idle_after_rst_in_ready", o_in_ready, 0);

      // Fresh signed job with a stray start pulse during COMPUTE.
      a_m = '{255, 2, 3, 252, 0, 0};
      b_m = '{5, 6, 7, 8, 0, 0};
      run_job(0, 2, 2, 2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule : tb_mat_mult_stream

`default_nettype wire
